// File: rtl/hack_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_cpu_pkg
//  Description : Shared types and constants for the Hack CPU bus core:
//                FSM state encoding, jump-condition codes and the bit
//                positions of the C-instruction fields.
//  Revision    : 1.0  initial release
// ============================================================================
package hack_cpu_pkg;

  // Sequencer states of the multi-cycle core
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MREAD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MWRITE = 3'd4
  } state_t;

  // Jump-condition codes (instruction bits [2:0])
  localparam logic [2:0] c_jmp_none = 3'b000;
  localparam logic [2:0] c_jgt      = 3'b001;
  localparam logic [2:0] c_jeq      = 3'b010;
  localparam logic [2:0] c_jge      = 3'b011;
  localparam logic [2:0] c_jlt      = 3'b100;
  localparam logic [2:0] c_jne      = 3'b101;
  localparam logic [2:0] c_jle      = 3'b110;
  localparam logic [2:0] c_jmp      = 3'b111;

  // C-instruction field positions; all fields live in the low 16 bits
  localparam int c_inst_w      = 16;
  localparam int c_bit_a       = 12;  // y operand select: 1 = M, 0 = A
  localparam int c_bit_zx      = 11;
  localparam int c_bit_nx      = 10;
  localparam int c_bit_zy      = 9;
  localparam int c_bit_ny      = 8;
  localparam int c_bit_f       = 7;
  localparam int c_bit_no      = 6;
  localparam int c_bit_dest_a  = 5;
  localparam int c_bit_dest_d  = 4;
  localparam int c_bit_dest_m  = 3;
  localparam int c_jump_msb    = 2;
  localparam int c_jump_lsb    = 0;

endpackage : hack_cpu_pkg
`default_nettype wire

// File: rtl/hack_alu.sv
`default_nettype none
// ============================================================================
//  Module      : hack_alu
//  Description : Width-parametrised Hack ALU. Six control bits condition the
//                operands (zero / negate), pick add or and, and optionally
//                negate the result. Flags report zero and sign of the result.
//  Revision    : 1.0  initial release
// ============================================================================
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] w_x_z;
  logic [WIDTH-1:0] w_x_n;
  logic [WIDTH-1:0] w_y_z;
  logic [WIDTH-1:0] w_y_n;
  logic [WIDTH-1:0] w_fn;

  // Operand conditioning, function select and output negation
  always_comb begin
    w_x_z = zx ? '0 : x;
    w_x_n = nx ? ~w_x_z : w_x_z;
    w_y_z = zy ? '0 : y;
    w_y_n = ny ? ~w_y_z : w_y_z;
    w_fn  = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    out   = no ? ~w_fn : w_fn;
    zr    = (out == '0);
    ng    = out[WIDTH-1];
  end

endmodule : hack_alu
`default_nettype wire

// File: rtl/hack_cpu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : hack_cpu_bus
//  Description : Multi-cycle Hack CPU with separate request/ready instruction
//                and data buses. One instruction is walked through
//                FETCH -> DECODE -> [MREAD] -> EXEC -> [MWRITE]; each bus
//                request holds its address/data until the matching ready.
//  Revision    : 1.0  initial release
// ============================================================================
module hack_cpu_bus
  import hack_cpu_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  // instruction bus
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  // data bus
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ready,
  input  logic [WIDTH-1:0] dmem_rdata,
  // status
  output logic [WIDTH-1:0] pc,
  output logic             retire
);

  // --------------------------------------------------------------------------
  // Architectural and sequencing state
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_addr_q;   // M-write address: A before the EXEC update
  logic [WIDTH-1:0] r_res_q;    // M-write data: ALU result of EXEC

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic             w_is_c;
  logic             w_abit;
  logic             w_dest_a;
  logic             w_dest_d;
  logic             w_dest_m;
  logic [2:0]       w_jump;
  logic [WIDTH-1:0] w_alu_y;
  logic [WIDTH-1:0] w_alu_out;
  logic             w_zr;
  logic             w_ng;
  logic             w_jump_taken;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_unused_ir;

  assign w_is_c   = r_ir[WIDTH-1];
  assign w_abit   = r_ir[c_bit_a];
  assign w_dest_a = r_ir[c_bit_dest_a];
  assign w_dest_d = r_ir[c_bit_dest_d];
  assign w_dest_m = r_ir[c_bit_dest_m];
  assign w_jump   = r_ir[c_jump_msb:c_jump_lsb];

  // Bits between the opcode and the a-bit carry no meaning in a C-instruction
  assign w_unused_ir = ^r_ir[WIDTH-2:c_bit_a+1];

  // y operand is memory when the a-bit is set, otherwise the A register
  assign w_alu_y  = w_abit ? r_m : r_a;

  // Sequential pc wraps naturally at 2^WIDTH
  assign w_pc_inc = r_pc + {{(WIDTH-1){1'b0}}, 1'b1};

  hack_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .x   (r_d),
    .y   (w_alu_y),
    .zx  (r_ir[c_bit_zx]),
    .nx  (r_ir[c_bit_nx]),
    .zy  (r_ir[c_bit_zy]),
    .ny  (r_ir[c_bit_ny]),
    .f   (r_ir[c_bit_f]),
    .no  (r_ir[c_bit_no]),
    .out (w_alu_out),
    .zr  (w_zr),
    .ng  (w_ng)
  );

  // Jump condition from the ALU flags of the current result
  always_comb begin
    w_jump_taken = 1'b0;
    case (w_jump)
      c_jmp_none: w_jump_taken = 1'b0;
      c_jgt:      w_jump_taken = !w_zr && !w_ng;
      c_jeq:      w_jump_taken = w_zr;
      c_jge:      w_jump_taken = !w_ng;
      c_jlt:      w_jump_taken = w_ng;
      c_jne:      w_jump_taken = !w_zr;
      c_jle:      w_jump_taken = w_zr || w_ng;
      c_jmp:      w_jump_taken = 1'b1;
      default:    w_jump_taken = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer: advances on bus readies and commits architectural state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_a      <= '0;
      r_d      <= '0;
      r_ir     <= '0;
      r_m      <= '0;
      r_addr_q <= '0;
      r_res_q  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (!w_is_c) begin
            r_a     <= r_ir;
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end else if (w_abit) begin
            r_state <= ST_MREAD;
          end else begin
            r_state <= ST_EXEC;
          end
        end

        ST_MREAD: begin
          if (dmem_ready) begin
            r_m     <= dmem_rdata;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // Jump target and M-write address both use A from before this update
          if (w_dest_a) r_a <= w_alu_out;
          if (w_dest_d) r_d <= w_alu_out;
          r_pc     <= w_jump_taken ? r_a : w_pc_inc;
          r_addr_q <= r_a;
          r_res_q  <= w_alu_out;
          r_state  <= w_dest_m ? ST_MWRITE : ST_FETCH;
        end

        ST_MWRITE: begin
          if (dmem_ready) begin
            r_state <= ST_FETCH;
          end
        end

        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus and status outputs, decoded from registered state only (plus the
  // write-ready that completes MWRITE). The state register resets
  // asynchronously, so requests drop the moment rst_n falls; the fetch
  // request is additionally gated because FETCH is also the reset state.
  // --------------------------------------------------------------------------
  assign imem_req   = rst_n && (r_state == ST_FETCH);
  assign imem_addr  = r_pc;

  assign dmem_req   = (r_state == ST_MREAD) || (r_state == ST_MWRITE);
  assign dmem_we    = (r_state == ST_MWRITE);
  assign dmem_addr  = (r_state == ST_MWRITE) ? r_addr_q : r_a;
  assign dmem_wdata = r_res_q;

  assign pc         = r_pc;

  assign retire = ((r_state == ST_DECODE) && !w_is_c)
               || ((r_state == ST_EXEC)   && !w_dest_m)
               || ((r_state == ST_MWRITE) && dmem_ready);

endmodule : hack_cpu_bus
`default_nettype wire

// File: doc/hack_cpu_bus.md
HACK_CPU_BUS -- requirements
Module: hack_cpu_bus

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath/address width (>=16; C-instruction fields decode from the low 16 bits, opcode = bit WIDTH-1).
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  WIDTH  fetch address (= pc).
REQ-008 imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  input  WIDTH  instruction word.
REQ-010 dmem_req  output  1  data access request.
REQ-011 dmem_we  output  1  1 = write, 0 = read; valid while dmem_req.
REQ-012 dmem_addr  output  WIDTH  data address.
REQ-013 dmem_wdata  output  WIDTH  write data.
REQ-014 dmem_ready  input  1  access complete; dmem_rdata valid on reads.
REQ-015 dmem_rdata  input  WIDTH  read data.
REQ-016 pc  output  WIDTH  program counter.
REQ-017 retire  output  1  one-cycle pulse per completed instruction.

Function
REQ-018 SHALL implement the FSM FETCH, DECODE, MREAD, EXEC, MWRITE.
- FETCH: imem_req=1, imem_addr=pc. When imem_ready is high, latch IR and go to DECODE. Otherwise hold.
- DECODE:
  - A-instruction: A<=IR, pc<=pc+1, retire, go to FETCH.
  - C-instruction with a-bit (bit 12)=1: go to MREAD.
  - Any other C-instruction: go to EXEC.
- MREAD: dmem_req=1, we=0, addr=A. On dmem_ready, latch M<=dmem_rdata and go to EXEC.
- EXEC: compute ALU with x=D and y=(a-bit ? M : A). Commit A/D/pc. Capture addr_q=A (pre-update) and res_q=alu_out.
  - dest[0]=1: go to MWRITE.
  - Otherwise: retire and go to FETCH.
- MWRITE: dmem_req=1, we=1, addr=addr_q, wdata=res_q. On dmem_ready, retire and go to FETCH.
REQ-019 A request, once raised, SHALL hold addr/we/wdata stable until its ready is sampled high; ready outside a request SHALL be ignored.
REQ-020 Ready SHALL be accepted in the same cycle as the request (zero wait states). A-instruction = 2 cycles; C without memory = 3; C with read or write = 4; C with read and write = 5.
REQ-021 Jump conditions from ALU zr/ng SHALL be: 000 none; 001 JGT; 010 JEQ; 011 JGE; 100 JLT; 101 JNE; 110 JLE; 111 JMP.
- Taken: pc<=A as it was before the EXEC update.
- Not taken: pc<=pc+1.
REQ-022 dest[2]/dest[1] SHALL load A/D with alu_out in EXEC. A write to M SHALL use the pre-update A as address (e.g. AM=...).
REQ-023 pc+1 SHALL wrap modulo 2^WIDTH.
REQ-024 Outside MREAD/MWRITE: dmem_req=0 and dmem_we=0. Outside FETCH: imem_req=0.

Reset
REQ-025 While rst_n=0:
- state=FETCH; pc=RESET_PC; A, D, IR, M, addr_q, res_q = 0.
- imem_req, dmem_req, dmem_we, retire = 0 asynchronously, including mid-transaction. Pending accesses are abandoned.
REQ-026 The first cycle after rst_n rises SHALL issue a fetch at RESET_PC.

Structure
REQ-027 Package hack_cpu_pkg SHALL hold the state enum, jump-code constants and instruction field bit positions.
REQ-028 The existing hack_alu (WIDTH-parametrised) SHALL be the only sub-module; the jump evaluator stays inline.

Verification
REQ-029 Zero-wait memory, program 0x0005 then 0xEC10 (D=A): D=5, retire pulses at cycles 2 and 5, pc=2.
REQ-030 imem_ready low for 10 cycles: imem_req held, imem_addr stable, no state/register change, no retire.
REQ-031 A=100, D=7, M=D+1 (0xE7C8), dmem_ready delayed 3 cycles: dmem_req=1, we=1, addr=100, wdata=8 stable until ready; retire on the ready cycle.
REQ-032 A=0x20, mem[0x20]=9, AM=M+1 (0xFDE8): read addr 0x20, then write addr 0x20 data 10; A=10 at end; 5 cycles.
REQ-033 Jump cases, via 0xEE90 (D=-1), @50, 0xE304 (D;JLT):
- JLT taken: pc=50.
- With D=1, JLT not taken: pc increments.
- pc=0xFFFF with a non-jump instruction: pc wraps to 0.
REQ-034 rst_n dropped during an MREAD wait: dmem_req falls without a clock edge, pc=RESET_PC, no retire. After release, imem_addr=RESET_PC.
